// File: rtl/cpu_pkg.sv
// Shared CPU-side constants and the state type for the pending-index encoder.
package cpu_pkg;

    localparam int REG_COUNT = 32;
    localparam int REG_IDX_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } enc_state_t;

endpackage

// File: rtl/lowest_set_encoder.sv
// Combinational priority encoder: index of the lowest set bit, plus any/single flags.
module lowest_set_encoder #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 5
) (
    input  logic [WIDTH-1:0] i_mask,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any,
    output logic             o_single
);

    // Scan from the top so the lowest set bit is the one that sticks.
    always_comb begin
        o_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx = i[IDX_W-1:0];
            end
        end
    end

    assign o_any    = |i_mask;
    assign o_single = o_any && ((i_mask & (i_mask - WIDTH'(1))) == '0);

endmodule

// File: rtl/pending_index_encoder.sv
// Serialises a multi-hot request mask into one index per cycle, lowest first.
// Handshake: a transfer happens on a side only in a cycle where its valid and ready are both high.
module pending_index_encoder
    import cpu_pkg::*;
#(
    parameter int WIDTH = REG_COUNT,
    parameter int IDX_W = REG_IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mask,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             zero_mask,
    output logic             busy,
    output enc_state_t       dbg_state
);

    enc_state_t       r_state;
    enc_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_pending;
    logic [WIDTH-1:0] w_pending_nxt;
    logic             r_zero_mask;
    logic             w_zero_mask_nxt;

    logic [IDX_W-1:0] w_idx;
    logic             w_any;
    logic             w_single;

    lowest_set_encoder #(
        .WIDTH(WIDTH),
        .IDX_W(IDX_W)
    ) u_lse (
        .i_mask  (r_pending),
        .o_idx   (w_idx),
        .o_any   (w_any),
        .o_single(w_single)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pending   <= '0;
            r_zero_mask <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pending   <= w_pending_nxt;
            r_zero_mask <= w_zero_mask_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pending_nxt   = r_pending;
        w_zero_mask_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (!flush && in_valid) begin
                    if (in_mask != '0) begin
                        w_pending_nxt = in_mask;
                        w_state_nxt   = EMIT;
                    end else begin
                        w_zero_mask_nxt = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (flush) begin
                    w_pending_nxt = '0;
                    w_state_nxt   = IDLE;
                end else if (out_ready) begin
                    // Clearing the lowest set bit is exactly clearing bit out_idx.
                    w_pending_nxt = r_pending & (r_pending - WIDTH'(1));
                    if (w_single) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_pending_nxt = '0;
            end
        endcase
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == EMIT);
    assign out_valid = (r_state == EMIT) && w_any;
    assign out_idx   = out_valid ? w_idx : '0;
    assign out_last  = out_valid && w_single;
    assign zero_mask = r_zero_mask;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_pending_index_encoder.sv
// Directed bench for pending_index_encoder with hand-computed expected indices.
module tb_pending_index_encoder;
    import cpu_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_mask;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic        out_last;
    logic        zero_mask;
    logic        busy;
    enc_state_t  dbg_state;

    int n_checks;
    int n_fail;
    logic [4:0] exp_q[$];

    pending_index_encoder dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mask  (in_mask),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_idx  (out_idx),
        .out_last (out_last),
        .zero_mask(zero_mask),
        .busy     (busy),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".in_ready"},  32'(in_ready),  32'd1);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".out_idx"},   32'(out_idx),   32'd0);
        chk({tag, ".out_last"},  32'(out_last),  32'd0);
        chk({tag, ".busy"},      32'(busy),      32'd0);
        chk({tag, ".state"},     32'(dbg_state), 32'(IDLE));
    endtask

    // ---------------- drivers ----------------
    task automatic send_mask(input logic [31:0] m);
        in_valid = 1'b1;
        in_mask  = m;
        tick();
        in_valid = 1'b0;
        in_mask  = '0;
    endtask

    // Expect every set bit of m, lowest first, one per cycle with out_ready high.
    // When poke is set, a second mask is offered throughout and must be ignored.
    task automatic drain(input string tag, input logic [31:0] m, input bit poke);
        int n;
        exp_q.delete();
        for (int i = 0; i < 32; i++) begin
            if (m[i]) exp_q.push_back(5'(i));
        end
        n = exp_q.size();
        out_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            logic [4:0] e;
            e = exp_q.pop_front();
            if (poke) begin
                in_valid = 1'b1;
                in_mask  = 32'h0000_0001;
            end
            chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".out_idx"},   32'(out_idx),   32'(e));
            chk({tag, ".out_last"},  32'(out_last),  32'(k == n - 1));
            chk({tag, ".in_ready"},  32'(in_ready),  32'd0);
            chk({tag, ".busy"},      32'(busy),      32'd1);
            tick();
        end
        in_valid = 1'b0;
        in_mask  = '0;
        chk_idle({tag, ".done"});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_mask   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk_idle("reset");
        chk("reset.zero_mask", 32'(zero_mask), 32'd0);

        // Three sparse bits drain in three cycles, in_ready back right after.
        out_ready = 1'b1;
        send_mask(32'h8000_0011);
        chk("m11.idx0",  32'(out_idx),  32'd0);
        chk("m11.last0", 32'(out_last), 32'd0);
        chk("m11.state", 32'(dbg_state), 32'(EMIT));
        tick();
        chk("m11.idx4",  32'(out_idx),  32'd4);
        chk("m11.last4", 32'(out_last), 32'd0);
        tick();
        chk("m11.idx31",  32'(out_idx),  32'd31);
        chk("m11.last31", 32'(out_last), 32'd1);
        tick();
        chk_idle("m11.end");

        // All-zero mask: single-cycle zero_mask pulse, no output.
        send_mask(32'h0);
        chk("zero.pulse",     32'(zero_mask), 32'd1);
        chk("zero.out_valid", 32'(out_valid), 32'd0);
        chk("zero.in_ready",  32'(in_ready),  32'd1);
        tick();
        chk("zero.pulse_end", 32'(zero_mask), 32'd0);
        chk_idle("zero.after");

        // Stall: index 8 held steady while out_ready is low.
        out_ready = 1'b0;
        send_mask(32'h0000_0300);
        for (int s = 0; s < 3; s++) begin
            chk("stall.valid", 32'(out_valid), 32'd1);
            chk("stall.idx",   32'(out_idx),   32'd8);
            chk("stall.last",  32'(out_last),  32'd0);
            tick();
        end
        drain("stall", 32'h0000_0300, 1'b0);

        // Full mask with a competing in_valid during the drain.
        out_ready = 1'b1;
        send_mask(32'hFFFF_FFFF);
        drain("full", 32'hFFFF_FFFF, 1'b1);
        tick();
        chk_idle("full.ignored");

        // Single top bit.
        send_mask(32'h8000_0000);
        drain("bit31", 32'h8000_0000, 1'b0);

        // Reset mid-EMIT discards remaining indices.
        send_mask(32'h0000_0096);
        chk("rst.idx1", 32'(out_idx), 32'd1);
        tick();
        chk("rst.idx2", 32'(out_idx), 32'd2);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk_idle("rst.after");
        tick();
        chk_idle("rst.quiet");

        // Flush after first handshake; simultaneous out handshake is dropped.
        send_mask(32'h0000_F000);
        chk("flush.idx12", 32'(out_idx), 32'd12);
        tick();
        chk("flush.idx13", 32'(out_idx), 32'd13);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_idle("flush.after");
        tick();
        chk_idle("flush.quiet");
        send_mask(32'h0000_0002);
        chk("flush.next_idx",  32'(out_idx),  32'd1);
        chk("flush.next_last", 32'(out_last), 32'd1);
        tick();
        chk_idle("flush.next_end");

        // Flush in IDLE beats in_valid, for both nonzero and zero masks.
        flush = 1'b1;
        send_mask(32'h0000_0004);
        chk_idle("iflush.nz");
        send_mask(32'h0);
        flush = 1'b0;
        chk("iflush.zero_mask", 32'(zero_mask), 32'd0);
        chk_idle("iflush.z");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
